// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus for the fetch stage.
// master: fetch stage (drives request/address), slave: instruction memory.
interface if_fetch_stage_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;

  modport master (output imemReq, output imemAddr, input imemAck, input imemRdata);
  modport slave  (input imemReq, input imemAddr, output imemAck, output imemRdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: next-PC generation, imem handshake, IF/ID register.
// Optional performance counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  output logic [31:0] nextPC,
  output logic        isPCWrite,
  if_fetch_stage_if.master imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        ifidValid,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPC,
  output logic [31:0] ifidPC4
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] bubbleCount
`endif
);

  typedef enum logic [1:0] {S_INIT, S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_reqAddr;
  logic [31:0] r_holdInstr;

  logic        w_pcWrite;
  logic [31:0] w_nextPC;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_load;
  logic [31:0] w_loadInstr;
  logic        w_flush;
  logic        w_capture;
  logic        w_latchAddr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_stateNext;
  end

  // Next-state, PC write port, imem request and IF/ID load decisions
  always_comb begin
    w_stateNext = r_state;
    w_pcWrite   = 1'b0;
    w_nextPC    = PC;
    w_req       = 1'b0;
    w_addr      = PC;
    w_load      = 1'b0;
    w_loadInstr = imem.imemRdata;
    w_flush     = 1'b0;
    w_capture   = 1'b0;
    w_latchAddr = 1'b0;
    case (r_state)
      S_INIT: begin
        w_pcWrite   = 1'b1;
        w_nextPC    = RESET_PC;
        w_stateNext = S_FETCH;
      end
      S_FETCH: begin
        w_req       = 1'b1;
        w_latchAddr = 1'b1;
        if (redirect) begin
          w_stateNext = imem.imemAck ? S_FETCH : S_DROP;
        end else if (imem.imemAck) begin
          if (stall) begin
            w_capture   = 1'b1;
            w_stateNext = S_HOLD;
          end else begin
            w_load    = 1'b1;
            w_pcWrite = 1'b1;
            w_nextPC  = PC + 32'd4;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_stateNext = S_FETCH;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_loadInstr = r_holdInstr;
          w_pcWrite   = 1'b1;
          w_nextPC    = PC + 32'd4;
          w_stateNext = S_FETCH;
        end
      end
      S_DROP: begin
        w_req  = 1'b1;
        w_addr = r_reqAddr;
        if (imem.imemAck) w_stateNext = S_FETCH;
      end
      default: w_stateNext = S_INIT;
    endcase
    // Redirect overrides whatever the state decided, including a stall.
    if (redirect && (r_state != S_INIT)) begin
      w_pcWrite = 1'b1;
      w_nextPC  = redirectTarget & 32'hFFFF_FFFC;
      w_flush   = 1'b1;
    end
  end

  assign isPCWrite     = w_pcWrite & rst_n;
  assign nextPC        = w_nextPC;
  assign imem.imemReq  = w_req & rst_n;
  assign imem.imemAddr = w_addr;

  // Outstanding-request address and word captured during a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reqAddr   <= '0;
      r_holdInstr <= '0;
    end else begin
      if (w_latchAddr) r_reqAddr   <= PC;
      if (w_capture)   r_holdInstr <= imem.imemRdata;
    end
  end

  // IF/ID pipeline register: flush on redirect, load on accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifidValid <= 1'b0;
      ifidInstr <= NOP_INSTR;
      ifidPC    <= '0;
      ifidPC4   <= '0;
    end else if (w_flush) begin
      ifidValid <= 1'b0;
      ifidInstr <= NOP_INSTR;
    end else if (w_load) begin
      ifidValid <= 1'b1;
      ifidInstr <= w_loadInstr;
      ifidPC    <= PC;
      ifidPC4   <= PC + 32'd4;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_fetchCount;
  logic [31:0] r_bubbleCount;
  logic        w_validNext;

  assign w_validNext = w_flush ? 1'b0 : (w_load ? 1'b1 : ifidValid);

  // Count valid IF/ID loads and post-edge bubbles outside INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchCount  <= '0;
      r_bubbleCount <= '0;
    end else begin
      if (w_load && !w_flush)                  r_fetchCount  <= r_fetchCount + 32'd1;
      if ((r_state != S_INIT) && !w_validNext) r_bubbleCount <= r_bubbleCount + 32'd1;
    end
  end

  assign fetchCount  = r_fetchCount;
  assign bubbleCount = r_bubbleCount;
`endif

endmodule
